if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- IF-stage fetch unit. Owns the architectural PC and drives a req/ack instruction-memory port.
- Produces the IF/ID pipeline register.
- Exports pc_plus4 to the PC branch mux. Consumes the mux output pc_new when MEM resolves a taken branch/jump (redirect).
- Handles hazard stalls with a 1-entry skid buffer, and kills in-flight fetches on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction value presented in IF/ID when the entry is invalid.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- pc_new  in  32  next-PC from PC branch mux; sampled only when redirect=1.
- redirect  in  1  MEM-stage branch/jump taken; flush IF.
- stall  in  1  hazard unit: hold IF/ID.
- pc_plus4  out  32  pc+4, combinational from pc; feeds the mux sequential input.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  memory accepts the request and returns data this cycle; may assert in the same cycle as req.
- imem_rdata  in  32  instruction, valid when imem_ack=1.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  32  PC of the IF/ID instruction.
- ifid_instr  out  32  instruction; NOP_INSTR when invalid.
- ifid_misalign  out  1  see Optional Feature; 0 when the feature is compiled out.

Behaviour:
- Reset (async, rstn=0):
  - pc=RESET_PC, req_addr=RESET_PC, state=FETCH.
  - imem_req=0 while rstn=0.
  - ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_misalign=0, skid buffer empty.
  - First request is issued in the first cycle after rstn deasserts.
- State FETCH: imem_req=1, imem_addr=req_addr (req_addr tracks pc).
  - On ack, redirect=0, stall=0:
    - IF/ID <= {1, req_addr, imem_rdata}.
    - pc <= pc+4 (pc_plus4).
    - Next request is issued the following cycle.
    - Zero-wait memory sustains 1 instr/cycle; latency is req to IF/ID = 1 clock after ack.
  - On ack, stall=1, redirect=0:
    - IF/ID holds.
    - Instruction and PC go into the skid buffer; pc <= pc+4; state -> BUFFERED.
  - No ack: hold req and addr; IF/ID <= invalid unless stall=1, in which case it holds.
- State BUFFERED: imem_req=0.
  - stall=1: IF/ID and buffer hold.
  - stall=0: IF/ID <= buffer entry, buffer empties, state -> FETCH.
- State KILL: imem_req=1 at the old req_addr, held until ack.
  - On ack: discard data, req_addr <= pc (the redirect target), state -> FETCH.
  - A further redirect during KILL updates pc only.
- Redirect (priority over stall and ack, in any state):
  - pc <= pc_new.
  - IF/ID <= invalid (valid=0, instr=NOP_INSTR).
  - Skid buffer cleared.
  - FETCH with ack the same cycle: data discarded, req_addr <= pc_new, state stays FETCH.
  - FETCH without ack (request outstanding): state -> KILL; req_addr unchanged.
  - BUFFERED: state -> FETCH, req_addr <= pc_new.
- No instruction is ever duplicated or lost across stall/redirect.
- Ack while imem_req=0 is ignored.
- PC arithmetic is 32-bit and wraps (32'hFFFF_FFFC + 4 = 0).
- Reset mid-transaction: all state is abandoned immediately; memory must tolerate req dropping.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- With it:
  - If a redirect target has pc_new[1:0] != 0, no fetch is issued for it.
  - Next cycle: IF/ID <= {valid=1, pc=pc_new, instr=NOP_INSTR, misalign=1}.
  - Fetch then idles (imem_req=0) until the next redirect.
  - A pending KILL still completes first.
- Without it: pc_new[1:0] is forced to 0 when loaded, and ifid_misalign is tied to 0.

Test Plan:
- Reset release, zero-wait ack, rdata=addr^32'hA5A5_0000 -> ifid_pc = 0,4,8,C on consecutive cycles, instr matching, ifid_valid=1 from cycle 2.
- stall=1 for 3 cycles while ack arrives at addr 0x8 -> IF/ID holds 0x4; on release, 0x8 appears then 0xC; no address skipped or repeated.
- Ack delayed 3 cycles at 0x10 -> imem_addr stays 0x10, ifid_valid=0 meanwhile, imem_req continuous.
- redirect=1, pc_new=0x100 while 0x14 is outstanding with no ack -> KILL, 0x14 data discarded, next req addr 0x100, first valid ifid_pc=0x100.
- redirect with simultaneous ack and stall=1 -> IF/ID invalid next cycle, buffer empty, next fetch 0x100.
- (FETCH_MISALIGN_CHECK_EN) redirect to 0x102 -> ifid_misalign=1, ifid_pc=0x102, imem_req=0 until next redirect to 0x200 resumes fetch.

Source files
------------

// File: rtl/if_fetch_stage.sv
// IF-stage fetch unit: owns the PC, drives a req/ack instruction port and the IF/ID register.
// Optional misaligned-target trapping is compiled in with FETCH_MISALIGN_CHECK_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_new,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_misalign
);

    typedef enum logic [1:0] {FETCH, BUFFERED, KILL, IDLE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] req_addr_reg, req_addr_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic [31:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic        ack_ok;
    logic [31:0] target;
    logic        target_mis;
    logic        pc_mis;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        ifid_mis_reg, ifid_mis_next;
`endif

    assign pc_plus4  = pc_reg + 32'd4;
    assign imem_req  = rstn && ((state_reg == FETCH) || (state_reg == KILL));
    assign imem_addr = req_addr_reg;
    assign ack_ok    = imem_ack && imem_req;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target     = pc_new;
    assign target_mis = |pc_new[1:0];
    assign pc_mis     = |pc_reg[1:0];
`else
    assign target     = pc_new & 32'hFFFF_FFFC;
    assign target_mis = 1'b0;
    assign pc_mis     = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        req_addr_next   = req_addr_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;
        ifid_valid_next = ifid_valid_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
`ifdef FETCH_MISALIGN_CHECK_EN
        ifid_mis_next   = ifid_mis_reg;
`endif
        if (redirect) begin
            pc_next         = target;
            ifid_valid_next = 1'b0;
            ifid_instr_next = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
            ifid_mis_next   = 1'b0;
`endif
            // An outstanding request must still be drained before the target is fetched.
            if (imem_req && !ack_ok) begin
                state_next = KILL;
            end else begin
                req_addr_next = target;
                state_next    = target_mis ? IDLE : FETCH;
                if (target_mis) begin
                    ifid_valid_next = 1'b1;
                    ifid_pc_next    = target;
`ifdef FETCH_MISALIGN_CHECK_EN
                    ifid_mis_next   = 1'b1;
`endif
                end
            end
        end else begin
            case (state_reg)
                FETCH: begin
                    if (ack_ok) begin
                        pc_next       = pc_plus4;
                        req_addr_next = pc_plus4;
                        if (stall) begin
                            skid_pc_next    = req_addr_reg;
                            skid_instr_next = imem_rdata;
                            state_next      = BUFFERED;
                        end else begin
                            ifid_valid_next = 1'b1;
                            ifid_pc_next    = req_addr_reg;
                            ifid_instr_next = imem_rdata;
                        end
                    end else if (!stall) begin
                        ifid_valid_next = 1'b0;
                        ifid_instr_next = NOP_INSTR;
                    end
                end
                BUFFERED: begin
                    if (!stall) begin
                        ifid_valid_next = 1'b1;
                        ifid_pc_next    = skid_pc_reg;
                        ifid_instr_next = skid_instr_reg;
                        state_next      = FETCH;
                    end
                end
                KILL: begin
                    if (!stall) begin
                        ifid_valid_next = 1'b0;
                        ifid_instr_next = NOP_INSTR;
                    end
                    if (ack_ok) begin
                        req_addr_next = pc_reg;
                        state_next    = pc_mis ? IDLE : FETCH;
                        if (pc_mis) begin
                            ifid_valid_next = 1'b1;
                            ifid_pc_next    = pc_reg;
                            ifid_instr_next = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
                            ifid_mis_next   = 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    // Idle after a misaligned target: let the trap entry move on, then bubble.
                    if (!stall) begin
                        ifid_valid_next = 1'b0;
                        ifid_instr_next = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
                        ifid_mis_next   = 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            req_addr_reg   <= RESET_PC;
            skid_pc_reg    <= 32'd0;
            skid_instr_reg <= 32'd0;
            ifid_valid_reg <= 1'b0;
            ifid_pc_reg    <= 32'd0;
            ifid_instr_reg <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_addr_reg   <= req_addr_next;
            skid_pc_reg    <= skid_pc_next;
            skid_instr_reg <= skid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ifid_mis_reg <= 1'b0;
        else       ifid_mis_reg <= ifid_mis_next;
    end
    assign ifid_misalign = ifid_mis_reg;
`else
    assign ifid_misalign = 1'b0;
`endif

    assign ifid_valid = ifid_valid_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_instr = ifid_instr_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed test-plan sequences, then random stall/redirect/ack
// traffic checked every cycle against a queue-based fetch-stream model.
module tb_if_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc_new;
    logic        redirect, stall, imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus4, imem_addr, ifid_pc, ifid_instr;
    logic        imem_req, ifid_valid, ifid_misalign;

    int checks   = 0;
    int failures = 0;

    if_fetch_stage dut (
        .clk(clk), .rstn(rstn), .pc_new(pc_new), .redirect(redirect), .stall(stall),
        .pc_plus4(pc_plus4), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
        .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_misalign(ifid_misalign)
    );

    always #5 clk = ~clk;

    // Model: the PC, the address being requested, whether that request's data is to be
    // thrown away, at most one parked instruction, and the visible IF/ID entry.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    entry_t      m_skid[$];
    logic [31:0] m_pc, m_req_addr, m_ipc, m_instr;
    bit          m_discard, m_idle, m_valid, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_req();
        return !m_idle && (m_skid.size() == 0);
    endfunction

    task automatic model_reset();
        m_skid.delete();
        m_pc = 32'd0; m_req_addr = 32'd0; m_discard = 0; m_idle = 0;
        m_valid = 0; m_ipc = 32'd0; m_instr = NOP; m_mis = 0;
    endtask

    task automatic bubble();
        m_valid = 0; m_instr = NOP; m_mis = 0;
    endtask

    task automatic trap_entry(input logic [31:0] a);
        m_idle = 1; m_valid = 1; m_ipc = a; m_instr = NOP; m_mis = 1;
    endtask

    task automatic model_step(input bit s, input bit r, input logic [31:0] pn, input bit a);
        bit          req;
        bit          acc;
        logic [31:0] tgt;
        entry_t      e;
        req = model_req();
        acc = a && req;
`ifdef FETCH_MISALIGN_CHECK_EN
        tgt = pn;
`else
        tgt = {pn[31:2], 2'b00};
`endif
        if (r) begin
            m_skid.delete();
            bubble();
            m_pc = tgt;
            if (req && !acc) m_discard = 1;
            else begin
                m_discard = 0; m_req_addr = tgt; m_idle = 0;
                if (tgt[1:0] != 2'b00) trap_entry(tgt);
            end
        end else if (m_discard) begin
            if (!s) bubble();
            if (acc) begin
                m_discard = 0; m_req_addr = m_pc;
                if (m_pc[1:0] != 2'b00) trap_entry(m_pc);
            end
        end else if (m_skid.size() > 0) begin
            if (!s) begin
                e = m_skid.pop_front();
                m_valid = 1; m_ipc = e.pc; m_instr = e.instr; m_mis = 0;
            end
        end else if (m_idle) begin
            if (!s) bubble();
        end else if (acc) begin
            e.pc = m_req_addr; e.instr = m_req_addr ^ KEY;
            if (s) m_skid.push_back(e);
            else begin m_valid = 1; m_ipc = e.pc; m_instr = e.instr; m_mis = 0; end
            m_pc = m_pc + 32'd4;
            m_req_addr = m_pc;
        end else if (!s) begin
            bubble();
        end
    endtask

    task automatic compare_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, model_req()});
        chk("imem_addr", imem_addr, m_req_addr);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_misalign", {31'd0, ifid_misalign}, {31'd0, m_mis});
    endtask

    // Called at a falling edge: drive inputs, advance through one rising edge, compare.
    task automatic step(input bit s, input bit r, input logic [31:0] pn, input bit a);
        stall = s; redirect = r; pc_new = pn; imem_ack = a;
        imem_rdata = a ? (imem_addr ^ KEY) : $urandom;
        @(posedge clk);
        model_step(s, r, pn, a);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rstn = 1'b0; stall = 0; redirect = 0; pc_new = 0; imem_ack = 1; imem_rdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_pc", ifid_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        rstn = 1'b1;

        // zero-wait stream
        step(0, 0, 0, 1); chk("t1_pc0", ifid_pc, 32'h0); chk("t1_instr0", ifid_instr, KEY);
        step(0, 0, 0, 1); chk("t1_pc4", ifid_pc, 32'h4);
        // stall while 0x8 is acked
        step(1, 0, 0, 1); chk("t2_req_off", {31'd0, imem_req}, 32'd0);
        step(1, 0, 0, 1); step(1, 0, 0, 1); chk("t2_hold", ifid_pc, 32'h4);
        step(0, 0, 0, 0); chk("t2_pc8", ifid_pc, 32'h8);
        step(0, 0, 0, 1); chk("t2_pcC", ifid_pc, 32'hC);
        // delayed ack at 0x10
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("t3_addr", imem_addr, 32'h10);
            chk("t3_valid", {31'd0, ifid_valid}, 32'd0);
        end
        step(0, 0, 0, 1); chk("t3_pc10", ifid_pc, 32'h10);
        // redirect while 0x14 outstanding
        step(0, 1, 32'h100, 0); chk("t4_kill_addr", imem_addr, 32'h14);
        step(0, 0, 0, 1); chk("t4_new_addr", imem_addr, 32'h100);
        chk("t4_discard", {31'd0, ifid_valid}, 32'd0);
        step(0, 0, 0, 1); chk("t4_pc100", ifid_pc, 32'h100);
        step(0, 0, 0, 1);
        // redirect with ack and stall together
        step(1, 1, 32'h100, 1); chk("t5_valid", {31'd0, ifid_valid}, 32'd0);
        chk("t5_addr", imem_addr, 32'h100);
        step(0, 0, 0, 1); chk("t5_pc100", ifid_pc, 32'h100);
        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1); chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC); chk("wrap_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        step(0, 1, 32'h102, 1); chk("mis_flag", {31'd0, ifid_misalign}, 32'd1);
        chk("mis_pc", ifid_pc, 32'h102); chk("mis_req", {31'd0, imem_req}, 32'd0);
        step(0, 0, 0, 1); chk("mis_idle", {31'd0, imem_req}, 32'd0);
        step(0, 1, 32'h200, 0); chk("mis_resume", imem_addr, 32'h200);
`else
        step(0, 1, 32'h102, 1); chk("mask_addr", imem_addr, 32'h100);
`endif

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                #2 rstn = 1'b0;
                #1 chk("arst_req", {31'd0, imem_req}, 32'd0);
                chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
                model_reset();
                @(negedge clk);
                rstn = 1'b1;
            end
            step(($urandom % 4) == 0, ($urandom % 16) == 0,
                 ((($urandom % 2) == 0) ? 32'h0000_0FFF : 32'hFFFF_FFFF) & $urandom,
                 ($urandom % 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
